// File: rtl/z8_prog_loader.sv
// Byte-stream program loader: takes an instruction count and 40-bit words from the host,
// writes them to program memory, releases the core, then streams 256 data-memory words back.
`timescale 1ns/1ps

module z8_prog_loader #(
  parameter int unsigned RUN_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,

  output logic        pm_we,
  output logic [7:0]  pm_addr,
  output logic [39:0] pm_wdata,

  output logic [7:0]  dm_addr,
  input  logic [15:0] dm_rdata,

  output logic        core_reset,
  input  logic        core_halted,

  output logic        done,
  output logic        timed_out
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RUN,
    DUMP_RD,
    DUMP_HI,
    DUMP_LO,
    DONE
  } state_t;

  localparam bit          TO_EN   = (RUN_TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(RUN_TIMEOUT - 1) : 32'd0;

  state_t      state;
  state_t      state_nxt;

  logic        armed;
  logic [8:0]  n_words;
  logic [8:0]  word_idx;
  logic [8:0]  word_idx_inc;
  logic [2:0]  byte_idx;
  logic [39:0] shreg;
  logic [31:0] run_cnt;
  logic        rd_wait;
  logic [7:0]  dump_idx;
  logic [15:0] dump_word;

  logic        in_xfer;
  logic        more_words;
  logic        timeout_hit;

  assign in_xfer      = in_valid && in_ready;
  assign word_idx_inc = word_idx + 9'd1;
  assign more_words   = (word_idx_inc < n_words);
  assign timeout_hit  = TO_EN && (run_cnt == TO_LAST);

  assign pm_addr  = word_idx[7:0];
  assign pm_wdata = shreg;
  assign dm_addr  = dump_idx;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output and next-state variable gets a default before the case, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = dump_word[7:0];
    pm_we     = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        // armed stays low until the first edge after reset, keeping in_ready low in reset
        in_ready = armed;
        if (in_xfer) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = armed;
        if (in_xfer && byte_idx == 3'd4) state_nxt = WRITE;
      end
      WRITE: begin
        pm_we     = 1'b1;
        state_nxt = more_words ? LOAD : RUN;
      end
      RUN: begin
        if (core_halted || timeout_hit) state_nxt = DUMP_RD;
      end
      DUMP_RD: begin
        if (rd_wait) state_nxt = DUMP_HI;
      end
      DUMP_HI: begin
        out_valid = 1'b1;
        out_data  = dump_word[15:8];
        if (out_ready) state_nxt = DUMP_LO;
      end
      DUMP_LO: begin
        out_valid = 1'b1;
        out_data  = dump_word[7:0];
        if (out_ready) state_nxt = (dump_idx == 8'hFF) ? DONE : DUMP_RD;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      n_words    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      run_cnt    <= '0;
      rd_wait    <= 1'b0;
      dump_idx   <= '0;
      dump_word  <= '0;
      core_reset <= 1'b1;
      timed_out  <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (in_xfer) begin
            // a count byte of zero means a full 256-word program
            n_words  <= {(in_data == 8'd0), in_data};
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        LOAD: begin
          if (in_xfer) begin
            shreg    <= {shreg[31:0], in_data};
            byte_idx <= (byte_idx == 3'd4) ? 3'd0 : byte_idx + 3'd1;
          end
        end
        WRITE: begin
          word_idx <= word_idx_inc;
          if (!more_words) begin
            core_reset <= 1'b0;
            run_cnt    <= '0;
          end
        end
        RUN: begin
          run_cnt <= run_cnt + 32'd1;
          if (!core_halted && timeout_hit) timed_out <= 1'b1;
          if (core_halted || timeout_hit) begin
            dump_idx <= '0;
            rd_wait  <= 1'b0;
          end
        end
        DUMP_RD: begin
          // first cycle presents the address, second cycle captures the registered read data
          rd_wait <= ~rd_wait;
          if (rd_wait) dump_word <= dm_rdata;
        end
        DUMP_LO: begin
          if (out_ready && dump_idx != 8'hFF) dump_idx <= dump_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
